// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator sequencer.
//   - key code constants for the operator/control keys
//   - FSM state enum
//   - digit shift helper used for operand entry
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_SHOW = 2'd3
  } calc_state_t;

  // New digit enters on the right; the oldest digit falls off the left.
  function automatic logic [7:0] shift_digit(input logic [7:0] opnd,
                                             input logic [3:0] digit);
    return {opnd[3:0], digit};
  endfunction

endpackage

// File: rtl/calc_key_decode.sv
// calc_key_decode: combinational key classifier.
// Ports:
//   key_valid  in   strobe qualifying key_code
//   key_code   in   raw 4-bit key code
//   is_digit   out  valid key 0x0..0x9
//   is_op      out  valid add or subtract key
//   is_eq      out  valid equals key
//   is_clr     out  valid clear key
//   op_add     out  1 when key_code is the add key (meaningful with is_op)
// Codes 0xC/0xD assert none of the class outputs, so they fall through
// every FSM branch untouched.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic       op_add
);

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
  assign is_eq    = key_valid && (key_code == KEY_EQ);
  assign is_clr   = key_valid && (key_code == KEY_CLR);
  assign op_add   = (key_code == KEY_ADD);

endmodule

// File: rtl/calc_seq.sv
// calc_seq: keypad-entry sequencer for the two-digit BCD add/sub calculator.
// Builds operands from key strokes, waits SETTLE cycles for the external
// combinational datapath, then captures its result and flow flag.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   key_valid, key_code  one-cycle key strobe and code
//   res, flow            datapath result (BCD) and over/underflow flag
//   num1, num2, sel      operands and operation (1 = add) to the datapath
//   result, ovf          captured result and flow flag
//   busy                 waiting for the datapath to settle
//   done                 one-cycle pulse after capture
//   show_res             display should show result instead of operands
//
// state  | meaning
// S_A    | entering operand A (reset state)
// S_B    | entering operand B, operation chosen
// S_EXEC | datapath settling; operands frozen
// S_SHOW | result captured and displayed
module calc_seq
  import calc_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [7:0] res,
  input  logic       flow,
  output logic [7:0] num1,
  output logic [7:0] num2,
  output logic       sel,
  output logic [7:0] result,
  output logic       ovf,
  output logic       busy,
  output logic       done,
  output logic       show_res
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic is_digit, is_op, is_eq, is_clr, op_add;

  calc_key_decode u_decode (
    .key_valid (key_valid),
    .key_code  (key_code),
    .is_digit  (is_digit),
    .is_op     (is_op),
    .is_eq     (is_eq),
    .is_clr    (is_clr),
    .op_add    (op_add)
  );

  calc_state_t state_q, state_d;
  logic [7:0]  num1_q, num1_d;
  logic [7:0]  num2_q, num2_d;
  logic        sel_q, sel_d;
  logic [7:0]  result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_A;
      num1_q   <= 8'h00;
      num2_q   <= 8'h00;
      sel_q    <= 1'b1;
      result_q <= 8'h00;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    sel_d    = sel_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      S_A: begin
        if (is_digit) begin
          num1_d = shift_digit(num1_q, key_code);
        end else if (is_op) begin
          sel_d   = op_add;
          num2_d  = 8'h00;
          state_d = S_B;
        end else if (is_clr) begin
          num1_d = 8'h00;
        end
      end

      S_B: begin
        if (is_digit) begin
          num2_d = shift_digit(num2_q, key_code);
        end else if (is_op) begin
          sel_d = op_add;
        end else if (is_eq) begin
          cnt_d   = 4'd0;
          state_d = S_EXEC;
        end else if (is_clr) begin
          num1_d  = 8'h00;
          num2_d  = 8'h00;
          state_d = S_A;
        end
      end

      S_EXEC: begin
        // Clear wins even on the capture cycle; other keys are dropped.
        if (is_clr) begin
          num1_d  = 8'h00;
          num2_d  = 8'h00;
          state_d = S_A;
        end else if (cnt_q == CNT_LAST) begin
          result_d = res;
          ovf_d    = flow;
          done_d   = 1'b1;
          state_d  = S_SHOW;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SHOW: begin
        if (is_digit) begin
          num1_d  = {4'h0, key_code};
          num2_d  = 8'h00;
          state_d = S_A;
        end else if (is_op) begin
          num1_d  = result_q;
          num2_d  = 8'h00;
          sel_d   = op_add;
          state_d = S_B;
        end else if (is_eq) begin
          // Repeat last operation with the previous result as operand A.
          num1_d  = result_q;
          cnt_d   = 4'd0;
          state_d = S_EXEC;
        end else if (is_clr) begin
          num1_d   = 8'h00;
          num2_d   = 8'h00;
          result_d = 8'h00;
          ovf_d    = 1'b0;
          state_d  = S_A;
        end
      end

      default: state_d = S_A;
    endcase
  end

  assign num1     = num1_q;
  assign num2     = num2_q;
  assign sel      = sel_q;
  assign result   = result_q;
  assign ovf      = ovf_q;
  assign done     = done_q;
  assign busy     = (state_q == S_EXEC);
  assign show_res = (state_q == S_SHOW);

endmodule

// File: doc/calc_seq.md
# calc_seq

Keypad-entry sequencer for the two-digit BCD add/subtract calculator. It turns a stream of key codes into the operands `num1` and `num2` and the operation select `sel`. It waits a fixed settle time for the combinational add/sub datapath, then captures its result and flow flag into registers. It sits between the key scanner and the datapath/seven-segment display logic, and owns all calculator state.

## Interface
- `SETTLE`, default 2: cycles the datapath is given before capture; legal range 1..15.
- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_valid` input 1: one-cycle strobe; `key_code` is valid when high.
- `key_code` input 4: 0x0–0x9 digit, 0xA add, 0xB subtract, 0xE equals, 0xF clear; 0xC/0xD ignored.
- `res` input 8: BCD result from datapath (combinational in `num1`, `num2`, `sel`).
- `flow` input 1: datapath overflow/underflow flag.
- `num1` output 8: operand A, two BCD digits.
- `num2` output 8: operand B, two BCD digits.
- `sel` output 1: 1 = add, 0 = subtract.
- `result` output 8: captured BCD result.
- `ovf` output 1: captured flow flag.
- `busy` output 1: high in S_EXEC.
- `done` output 1: one-cycle pulse after capture.
- `show_res` output 1: high in S_SHOW; display shows `result` instead of operands.

## Operation
- States: S_A (enter A, reset state), S_B (enter B), S_EXEC, S_SHOW.
- Digit entry shifts left: `opnd <= {opnd[3:0], key_code}`. A third digit drops the oldest.
- S_A:
  - digit: shift into A.
  - op key: latch `sel`, clear B, go to S_B.
  - equals: ignored.
  - clear: A = 0.
- S_B:
  - digit: shift into B.
  - op key: overwrite `sel`, stay in S_B.
  - equals: clear settle counter, go to S_EXEC.
  - clear: A = B = 0, go to S_A.
- S_EXEC:
  - counter increments each cycle.
  - When counter == SETTLE-1: `result <= res`, `ovf <= flow`, go to S_SHOW.
  - clear: abort to S_A, A = B = 0, `result`/`ovf` unchanged, no `done`.
  - all other keys: dropped.
- S_SHOW:
  - digit: A = {0, digit}, B = 0, go to S_A (new calculation).
  - op key: A = `result`, B = 0, latch `sel`, go to S_B (chaining).
  - equals: A = `result`, B and `sel` kept, go to S_EXEC (repeat last operation).
  - clear: A = B = `result` = 0, `ovf` = 0, go to S_A.
- Ignored codes (0xC/0xD) never change any state in any state.

## Timing
- Reset values: state S_A, `num1` = `num2` = `result` = 0, `sel` = 1, `ovf` = `busy` = `done` = `show_res` = 0.
- Key effects are registered: they are visible on outputs the cycle after the `key_valid` edge.
- Equals accepted at edge k:
  - `busy` is high for cycles k+1..k+SETTLE.
  - capture happens at edge k+SETTLE.
  - `done` and `show_res` are high from k+SETTLE+1; `done` lasts exactly one cycle.
- `num1`, `num2` and `sel` are held stable for the whole of S_EXEC.
- `key_valid` on consecutive cycles: each strobe is processed.
- A key arriving in the same cycle as capture is dropped; clear in that cycle takes priority and aborts.
- Settle counter width is 4 bits.
- Reset mid-operation returns to reset values immediately and asynchronously.

## Structure
- Package `calc_pkg`:
  - key code constants `KEY_ADD`, `KEY_SUB`, `KEY_EQ`, `KEY_CLR`.
  - state enum `calc_state_t`.
- Sub-module `calc_key_decode`: combinational; maps `key_valid`/`key_code` to `is_digit`, `is_op`, `is_eq`, `is_clr`, plus a decoded `op_add` bit.
- `calc_seq` holds the FSM, operand registers, settle counter and result registers.

## Test plan
- Reset, then keys 1,2,ADD,3,4,EQ with the bench BCD model on `res` → `num1` = 0x12, `num2` = 0x34, `sel` = 1, `busy` for 2 cycles, `result` = 0x46, one `done` pulse, `show_res` = 1.
- Keys 7,8,9 in S_A → `num1` = 0x89. Then SUB,5,EQ → `sel` = 0, `result` = model(89−05) = 0x84.
- From S_SHOW with `result` = 0x46, keys ADD,1,1,EQ → `num1` = 0x46, `result` = 0x57. Then EQ again → `num1` = 0x57, `result` = 0x68.
- Keys 9,9,ADD,0,1,EQ with the model asserting `flow` → `ovf` = 1. A following CLR → `ovf` = 0, `result` = 0, state S_A.
- EQ followed by CLR in the next cycle (`SETTLE` = 4) → no `done`, `result` keeps its prior value, `num1` = `num2` = 0.
- Async `rst_n` low mid-S_EXEC → all outputs at reset values without a clock edge; keys 0xC/0xD in every state → no change.
